// File: rtl/prbs23_burst_ctrl.sv
// Burst framer for the x^23+x^18+1 PRBS generator: header words, PRBS payload, idle gap, repeat.
// Define PRBS23_BURST_IDX_HDR_EN to append a burst-index word after the fixed header words.
module prbs23_burst_ctrl #(
   parameter int unsigned       pDAT_W    = 8,
   parameter int unsigned       pLEN_W    = 16,
   parameter int unsigned       pHDR_LEN  = 2,
   parameter logic [pDAT_W-1:0] pHDR_WORD = pDAT_W'(8'hA5)
) (
   input  logic              iclk,
   input  logic              irst_n,
   input  logic              iclkena,
   input  logic              istart,
   input  logic              istop,
   input  logic [pLEN_W-1:0] iburst_len,
   input  logic [pLEN_W-1:0] igap_len,
   input  logic [pLEN_W-1:0] iburst_num,
   output logic              oprbs_ival,
   input  logic [pDAT_W-1:0] iprbs_dat,
   output logic              obusy,
   output logic              oval,
   output logic              osop,
   output logic              oeop,
   output logic [pDAT_W-1:0] odat,
   output logic [pLEN_W-1:0] oburst_idx
);

`ifdef PRBS23_BURST_IDX_HDR_EN
   localparam int unsigned HDR_WORDS = pHDR_LEN + 1;
`else
   localparam int unsigned HDR_WORDS = pHDR_LEN;
`endif
   localparam int unsigned HCNT_W = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_GAP} state_t;

   state_t              state_q, state_d;
   logic [pLEN_W-1:0]   len_q, len_d, gap_q, gap_d, num_q, num_d;
   logic [pLEN_W-1:0]   dcnt_q, dcnt_d, gcnt_q, gcnt_d, idx_q, idx_d;
   logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
   logic                stop_q, stop_d, busy_q, busy_d;
   logic                val_q, val_d, sop_q, sop_d, eop_q, eop_d, sel_q, sel_d;
   logic [pDAT_W-1:0]   hdr_q, hdr_d;

   logic [pLEN_W-1:0]   len_last, gap_last, num_last;
   logic                hdr_last, data_last, gap_done, last_burst, stop_req;

   // Compare against last index instead of count so a full-scale length never wraps early.
   assign len_last   = (len_q == '0) ? '0 : len_q - pLEN_W'(1);
   assign gap_last   = gap_q - pLEN_W'(1);
   assign num_last   = num_q - pLEN_W'(1);
   assign hdr_last   = (hcnt_q == HCNT_W'(HDR_WORDS - 1));
   assign data_last  = (dcnt_q == len_last);
   assign gap_done   = (gcnt_q == gap_last);
   assign last_burst = (num_q != '0) && (idx_q == num_last);
   assign stop_req   = stop_q | istop;

   // State register
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q <= ST_IDLE;
      end else if (iclkena) begin
         state_q <= state_d;
      end
   end

   // Next-state, counters and registered output values
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      gap_d   = gap_q;
      num_d   = num_q;
      hcnt_d  = hcnt_q;
      dcnt_d  = dcnt_q;
      gcnt_d  = gcnt_q;
      idx_d   = idx_q;
      stop_d  = stop_req;
      busy_d  = busy_q;
      val_d   = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      sel_d   = 1'b0;
      hdr_d   = hdr_q;
      case (state_q)
         ST_IDLE: begin
            stop_d = 1'b0;
            busy_d = 1'b0;
            if (istart) begin
               len_d   = iburst_len;
               gap_d   = igap_len;
               num_d   = iburst_num;
               idx_d   = '0;
               hcnt_d  = '0;
               dcnt_d  = '0;
               gcnt_d  = '0;
               busy_d  = 1'b1;
               state_d = ST_HDR;
            end
         end
         ST_HDR: begin
            val_d = 1'b1;
            sop_d = (hcnt_q == '0);
`ifdef PRBS23_BURST_IDX_HDR_EN
            hdr_d = (hcnt_q == HCNT_W'(pHDR_LEN)) ? pDAT_W'(idx_q) : pHDR_WORD;
`else
            hdr_d = pHDR_WORD;
`endif
            if (hdr_last) begin
               hcnt_d  = '0;
               dcnt_d  = '0;
               state_d = ST_DATA;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            val_d = 1'b1;
            sel_d = 1'b1;
            if (data_last) begin
               eop_d  = 1'b1;
               dcnt_d = '0;
               if (stop_req || last_burst) begin
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else if (gap_q == '0) begin
                  idx_d   = idx_q + 1'b1;
                  hcnt_d  = '0;
                  state_d = ST_HDR;
               end else begin
                  gcnt_d  = '0;
                  state_d = ST_GAP;
               end
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (gap_done) begin
               gcnt_d  = '0;
               hcnt_d  = '0;
               idx_d   = idx_q + 1'b1;
               state_d = ST_HDR;
            end else begin
               gcnt_d = gcnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         len_q  <= '0;
         gap_q  <= '0;
         num_q  <= '0;
         hcnt_q <= '0;
         dcnt_q <= '0;
         gcnt_q <= '0;
         idx_q  <= '0;
         stop_q <= 1'b0;
         busy_q <= 1'b0;
         val_q  <= 1'b0;
         sop_q  <= 1'b0;
         eop_q  <= 1'b0;
         sel_q  <= 1'b0;
         hdr_q  <= '0;
      end else if (iclkena) begin
         len_q  <= len_d;
         gap_q  <= gap_d;
         num_q  <= num_d;
         hcnt_q <= hcnt_d;
         dcnt_q <= dcnt_d;
         gcnt_q <= gcnt_d;
         idx_q  <= idx_d;
         stop_q <= stop_d;
         busy_q <= busy_d;
         val_q  <= val_d;
         sop_q  <= sop_d;
         eop_q  <= eop_d;
         sel_q  <= sel_d;
         hdr_q  <= hdr_d;
      end
   end

   // Generator advances on the same edge that registers sel, so payload needs no extra stage.
   assign oprbs_ival = iclkena && (state_q == ST_DATA);
   assign odat       = sel_q ? iprbs_dat : hdr_q;
   assign obusy      = busy_q;
   assign oval       = val_q;
   assign osop       = sop_q;
   assign oeop       = eop_q;
   assign oburst_idx = idx_q;

endmodule

// File: tb/tb_prbs23_burst_ctrl.sv
// Self-checking bench for prbs23_burst_ctrl: word-queue reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_prbs23_burst_ctrl;
   localparam int unsigned DW = 8;
   localparam int unsigned LW = 16;
   localparam int unsigned HL = 2;
   localparam logic [DW-1:0] HW = 8'hA5;
`ifdef PRBS23_BURST_IDX_HDR_EN
   localparam int HWORDS = HL + 1;
`else
   localparam int HWORDS = HL;
`endif

   logic          iclk, irst_n, iclkena, istart, istop;
   logic [LW-1:0] iburst_len, igap_len, iburst_num;
   logic          oprbs_ival, obusy, oval, osop, oeop;
   logic [DW-1:0] iprbs_dat, odat;
   logic [LW-1:0] oburst_idx;

   prbs23_burst_ctrl #(.pDAT_W(DW), .pLEN_W(LW), .pHDR_LEN(HL), .pHDR_WORD(HW)) dut (
      .iclk(iclk), .irst_n(irst_n), .iclkena(iclkena), .istart(istart), .istop(istop),
      .iburst_len(iburst_len), .igap_len(igap_len), .iburst_num(iburst_num),
      .oprbs_ival(oprbs_ival), .iprbs_dat(iprbs_dat), .obusy(obusy), .oval(oval),
      .osop(osop), .oeop(oeop), .odat(odat), .oburst_idx(oburst_idx)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // PRBS23 generator stand-in: DW bits per advance
   function automatic logic [22:0] gen_step(input logic [22:0] s);
      logic [22:0] r;
      r = s;
      for (int i = 0; i < int'(DW); i++) r = {r[21:0], r[22] ^ r[17]};
      return r;
   endfunction

   logic [22:0] gen_q = 23'h7FFFFF;
   always @(posedge iclk) if (oprbs_ival) gen_q <= gen_step(gen_q);
   assign iprbs_dat = gen_q[DW-1:0];

   // Reference model: a queue of the words still to be emitted by the current run
   typedef struct packed {
      logic          val;
      logic          sop;
      logic          eop;
      logic          is_dat;
      logic          bump;
      logic [DW-1:0] hdr;
   } item_t;

   item_t         q[$];
   logic [22:0]   m_gen = 23'h7FFFFF;
   int            m_len, m_gap, m_num, m_bcount;
   logic          m_stop;
   logic [LW-1:0] m_idx;
   logic          exp_val, exp_sop, exp_eop, exp_busy;
   logic [DW-1:0] exp_dat;

   task automatic push_burst(input int b);
      item_t it;
      int n;
      for (int i = 0; i < HWORDS; i++) begin
         it = '0;
         it.val = 1'b1;
         it.sop = (i == 0);
         it.hdr = (i < int'(HL)) ? HW : DW'(LW'(b));
         q.push_back(it);
      end
      n = (m_len == 0) ? 1 : m_len;
      for (int i = 0; i < n; i++) begin
         it = '0;
         it.val = 1'b1;
         it.is_dat = 1'b1;
         it.eop = (i == n - 1);
         q.push_back(it);
      end
   endtask

   task automatic model_reset();
      q.delete();
      exp_val = 0; exp_sop = 0; exp_eop = 0; exp_busy = 0; exp_dat = '0;
      m_idx = '0; m_stop = 0; m_bcount = 0;
   endtask

   task automatic model_step(input logic st, input logic sp,
                             input logic [LW-1:0] bl, input logic [LW-1:0] gl, input logic [LW-1:0] bn);
      item_t it;
      exp_val = 0; exp_sop = 0; exp_eop = 0;
      if (q.size() == 0) begin
         m_stop = 0;
         if (st) begin
            m_len = int'(bl); m_gap = int'(gl); m_num = int'(bn);
            m_idx = '0; m_bcount = 0;
            push_burst(0);
         end
      end else begin
         if (sp) m_stop = 1;
         it = q.pop_front();
         exp_val = it.val; exp_sop = it.sop; exp_eop = it.eop;
         if (it.is_dat) begin
            m_gen = gen_step(m_gen);
            exp_dat = m_gen[DW-1:0];
         end else if (it.val) begin
            exp_dat = it.hdr;
         end
         if (it.bump) m_idx = m_idx + 1'b1;
         if (it.eop && !m_stop && (m_num == 0 || m_bcount + 1 < m_num)) begin
            if (m_gap == 0) m_idx = m_idx + 1'b1;
            for (int i = 0; i < m_gap; i++) begin
               it = '0;
               it.bump = (i == m_gap - 1);
               q.push_back(it);
            end
            m_bcount++;
            push_burst(m_bcount);
         end
      end
      exp_busy = (q.size() > 0);
   endtask

   // Per-run observation counters used by the directed literal checks
   int cnt_val, cnt_sop, cnt_eop, cnt_ival, cnt_busy;
   logic [DW-1:0] seen[$];

   task automatic clear_counts();
      cnt_val = 0; cnt_sop = 0; cnt_eop = 0; cnt_ival = 0; cnt_busy = 0;
      seen.delete();
   endtask

   // Compare process: advance model on each enabled edge, check DUT 1 ns later
   always @(posedge iclk) begin
      logic en, st, sp, ival_e, exp_ival;
      logic [LW-1:0] bl, gl, bn;
      en = iclkena; st = istart; sp = istop; ival_e = oprbs_ival;
      bl = iburst_len; gl = igap_len; bn = iburst_num;
      if (!irst_n) model_reset();
      else if (en) model_step(st, sp, bl, gl, bn);
      #1;
      if (irst_n && en) begin
         cnt_val  += int'(oval);
         cnt_sop  += int'(osop);
         cnt_eop  += int'(oeop);
         cnt_busy += int'(obusy);
         cnt_ival += int'(ival_e);
         if (oval) seen.push_back(odat);
      end
      exp_ival = iclkena && irst_n && (q.size() > 0) && q[0].is_dat;
      chk("oval", 32'(oval), 32'(exp_val));
      chk("osop", 32'(osop), 32'(exp_sop));
      chk("oeop", 32'(oeop), 32'(exp_eop));
      chk("obusy", 32'(obusy), 32'(exp_busy));
      chk("oburst_idx", 32'(oburst_idx), 32'(m_idx));
      chk("oprbs_ival", 32'(oprbs_ival), 32'(exp_ival));
      if (exp_val) chk("odat", 32'(odat), 32'(exp_dat));
   end

   int en_mode = 0;
   always @(negedge iclk) begin
      case (en_mode)
         1:       iclkena <= ~iclkena;
         2:       iclkena <= ($urandom_range(0, 3) != 0);
         default: iclkena <= 1'b1;
      endcase
   end

   task automatic pulse(input bit is_stop);
      @(negedge iclk);
      if (is_stop) istop = 1'b1; else istart = 1'b1;
      do @(posedge iclk); while (!iclkena);
      @(negedge iclk);
      istart = 1'b0;
      istop  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin @(negedge iclk); n++; end while ((obusy || oval) && n < 5000);
      chk(tag, 32'(obusy | oval), 32'd0);
      repeat (3) @(negedge iclk);
   endtask

   task automatic set_cfg(input int l, input int g, input int n);
      iburst_len = LW'(l); igap_len = LW'(g); iburst_num = LW'(n);
   endtask

   initial begin
      logic [22:0] g;
      int n;
      int num_sav;
      irst_n = 1'b0; iclkena = 1'b1; istart = 1'b0; istop = 1'b0;
      set_cfg(0, 0, 0);
      repeat (3) @(negedge iclk);
      chk("rst_oval", 32'(oval), 0);
      chk("rst_obusy", 32'(obusy), 0);
      chk("rst_osop", 32'(osop), 0);
      chk("rst_oeop", 32'(oeop), 0);
      chk("rst_odat", 32'(odat), 0);
      chk("rst_idx", 32'(oburst_idx), 0);
      chk("rst_ival", 32'(oprbs_ival), 0);
      irst_n = 1'b1;
      repeat (2) @(negedge iclk);

      // Single burst: len=4 gap=2 num=1
      clear_counts();
      g = gen_q;
      set_cfg(4, 2, 1);
      pulse(0);
      wait_idle("t1_idle");
      chk("t1_val_cnt", 32'(cnt_val), 32'(HWORDS + 4));
      chk("t1_busy_cnt", 32'(cnt_busy), 32'(HWORDS + 4));
      chk("t1_ival_cnt", 32'(cnt_ival), 32'd4);
      chk("t1_sop_cnt", 32'(cnt_sop), 32'd1);
      chk("t1_eop_cnt", 32'(cnt_eop), 32'd1);
      chk("t1_hdr0", 32'(seen[0]), 32'h0A5);
      chk("t1_hdr1", 32'(seen[1]), 32'h0A5);
      for (int i = 0; i < 4; i++) begin
         g = gen_step(g);
         chk("t1_payload", 32'(seen[HWORDS + i]), 32'(g[DW-1:0]));
      end

      // Back-to-back bursts: len=3 gap=0 num=3
      clear_counts();
      g = gen_q;
      set_cfg(3, 0, 3);
      pulse(0);
      wait_idle("t2_idle");
      chk("t2_val_cnt", 32'(cnt_val), 32'(3 * (HWORDS + 3)));
      chk("t2_busy_cnt", 32'(cnt_busy), 32'(3 * (HWORDS + 3)));
      chk("t2_sop_cnt", 32'(cnt_sop), 32'd3);
      chk("t2_last_idx", 32'(oburst_idx), 32'd2);
      for (int b = 0; b < 3; b++)
         for (int i = 0; i < 3; i++) begin
            g = gen_step(g);
            chk("t2_payload", 32'(seen[b * (HWORDS + 3) + HWORDS + i]), 32'(g[DW-1:0]));
         end

      // Infinite run, stop in DATA of burst 5
      clear_counts();
      set_cfg(3, 1, 0);
      pulse(0);
      n = 0;
      while (cnt_sop < 6 && n < 2000) begin @(negedge iclk); n++; end
      chk("t3_reach_b5", 32'(cnt_sop), 32'd6);
      n = 0;
      while (!oprbs_ival && n < 50) begin @(negedge iclk); n++; end
      chk("t3_in_data", 32'(oprbs_ival), 32'd1);
      pulse(1);
      wait_idle("t3_idle");
      chk("t3_sop_cnt", 32'(cnt_sop), 32'd6);
      chk("t3_eop_cnt", 32'(cnt_eop), 32'd6);
      chk("t3_idx", 32'(oburst_idx), 32'd5);

      // Clock-enable toggling, len=4
      clear_counts();
      en_mode = 1;
      set_cfg(4, 2, 1);
      pulse(0);
      wait_idle("t4_idle");
      en_mode = 0;
      chk("t4_ival_cnt", 32'(cnt_ival), 32'd4);
      chk("t4_val_cnt", 32'(cnt_val), 32'(HWORDS + 4));
      chk("t4_sop_cnt", 32'(cnt_sop), 32'd1);
      chk("t4_eop_cnt", 32'(cnt_eop), 32'd1);
      chk("t4_hdr0", 32'(seen[0]), 32'h0A5);
      repeat (2) @(negedge iclk);

      // Reset during DATA word 2
      clear_counts();
      set_cfg(6, 1, 0);
      pulse(0);
      n = 0;
      while (!(cnt_ival == 2 && oprbs_ival) && n < 200) begin @(negedge iclk); n++; end
      chk("t5_in_word2", 32'(cnt_ival), 32'd2);
      irst_n = 1'b0;
      #1;
      chk("t5_oval", 32'(oval), 0);
      chk("t5_osop", 32'(osop), 0);
      chk("t5_oeop", 32'(oeop), 0);
      chk("t5_obusy", 32'(obusy), 0);
      chk("t5_odat", 32'(odat), 0);
      chk("t5_idx", 32'(oburst_idx), 0);
      chk("t5_ival", 32'(oprbs_ival), 0);
      repeat (2) @(negedge iclk);
      irst_n = 1'b1;
      clear_counts();
      set_cfg(2, 0, 1);
      pulse(0);
      wait_idle("t5_idle");
      chk("t5_sop_cnt", 32'(cnt_sop), 32'd1);
      chk("t5_idx_after", 32'(oburst_idx), 32'd0);

      // Start while busy is ignored; len=0 yields one payload word
      clear_counts();
      set_cfg(0, 0, 1);
      pulse(0);
      pulse(0);
      wait_idle("t6_idle");
      chk("t6_sop_cnt", 32'(cnt_sop), 32'd1);
      chk("t6_eop_cnt", 32'(cnt_eop), 32'd1);
      chk("t6_val_cnt", 32'(cnt_val), 32'(HWORDS + 1));
      chk("t6_ival_cnt", 32'(cnt_ival), 32'd1);

      // Randomized runs checked by the model
      for (int r = 0; r < 25; r++) begin
         en_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
         num_sav = int'($urandom_range(0, 3));
         set_cfg(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), num_sav);
         pulse(0);
         set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 2) == 0) pulse(0);
         if (num_sav == 0 || $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(2, 40)) @(negedge iclk);
            pulse(1);
         end
         wait_idle("rand_idle");
      end
      en_mode = 0;
      repeat (3) @(negedge iclk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prbs23_burst_ctrl.md
Name: prbs23_burst_ctrl

Overview:
Sequencer for the x^23+x^18+1 PRBS generator used in modem link tests. Frames the generator's output into bursts: header words, then PRBS payload, then an idle gap. Repeats for a programmed burst count or runs until stopped. Drives the generator's advance strobe and muxes header and payload into one framed stream for the modulator/BER path.

Parameters:
pDAT_W, 8, stream and generator word width (1..32)
pLEN_W, 16, width of burst-length, gap-length and burst-count fields
pHDR_LEN, 2, number of header words per burst (1..8)
pHDR_WORD, 8'hA5, header word value (pDAT_W bits)

Ports:
iclk  in  1  clock
irst_n  in  1  asynchronous active-low reset
iclkena  in  1  clock enable; all state frozen when 0
istart  in  1  start pulse; sampled in IDLE only
istop  in  1  graceful stop request; sampled any cycle
iburst_len  in  pLEN_W  payload words per burst; 0 treated as 1
igap_len  in  pLEN_W  idle cycles between bursts; 0 allowed
iburst_num  in  pLEN_W  bursts to send; 0 = infinite
oprbs_ival  out  1  advance strobe to generator ival
iprbs_dat  in  pDAT_W  generator odat
obusy  out  1  high from start acceptance to return to IDLE
oval  out  1  output word valid
osop  out  1  first header word of a burst
oeop  out  1  last payload word of a burst
odat  out  pDAT_W  output word
oburst_idx  out  pLEN_W  index of current burst, from 0

Behaviour:
- Reset: FSM=IDLE; all counters 0; obusy, oval, osop, oeop, oprbs_ival = 0; odat header register = 0; oburst_idx = 0.
- All registers update only when iclkena=1. When iclkena=0, nothing updates, including the generator strobe.
- States: IDLE, HDR, DATA, GAP.
- IDLE: on istart=1, latch iburst_len, igap_len and iburst_num into shadow registers, clear oburst_idx, go to HDR. Inputs are not re-sampled until the next start.
- HDR: emit pHDR_LEN header words, one per cycle. After the last one, go to DATA.
- DATA: oprbs_ival=1 combinationally, each enabled cycle, for len words. After the last word, go to GAP if the next burst is due, else IDLE.
- GAP: oval=0 for igap_len cycles, then go to HDR. oburst_idx increments on GAP exit. If gap=0, go DATA->HDR directly and increment oburst_idx there.
- Termination: stop after oburst_idx+1 == burst_num (when non-zero), or when a stop is pending at the end of DATA.
- istop: sets a sticky stop_pend flag. The current burst always completes. Stop in GAP or HDR still completes that burst's HDR/DATA. stop_pend clears in IDLE.
- Latency: the word for state-cycle t appears at the t+1 register edge.
  - oval, osop, oeop and the header/data select bit are registered.
  - odat = sel_q ? iprbs_dat : hdr_q, combinational mux. The generator output updates on the same edge as its ival, so payload aligns with no extra stage.
- osop is high only with header word 0. oeop is high with payload word len-1. With len=1 they are on different words, since the header is at least 1 word.
- obusy falls on the cycle the FSM enters IDLE. The last payload word is output one cycle after that, so oval may be 1 while obusy=0 for one cycle.
- istart while busy is ignored. Reset mid-burst aborts immediately with outputs to reset values. Generator state is not restored, so the payload stays continuous across bursts and across runs.
- Counters are pLEN_W wide. A length of 2^pLEN_W-1 must not wrap early.

Optional Feature:
PRBS23_BURST_IDX_HDR_EN
- Defined: one extra header word after the pHDR_LEN words. It carries oburst_idx[pDAT_W-1:0], zero-extended if pLEN_W < pDAT_W. The header is pHDR_LEN+1 words.
- Not defined: the header is exactly pHDR_LEN words of pHDR_WORD. No index word, no related logic.

Test Plan:
- len=4, gap=2, num=1, pHDR_LEN=2, pulse start:
  - oval sequence 1,1,1,1,1,1 then 0.
  - odat = A5,A5,P0..P3.
  - osop on word 0, oeop on P3.
  - obusy high for 6 cycles.
  - oprbs_ival high exactly 4 cycles.
- len=3, gap=0, num=3:
  - three back-to-back bursts with no idle cycle.
  - oburst_idx = 0,1,2.
  - 9 payload words, matching 9 consecutive generator outputs.
- num=0, assert istop mid-DATA of burst 5:
  - burst 5 completes with oeop.
  - no further osop.
  - returns to IDLE.
- Toggle iclkena 0/1 every other cycle during len=4:
  - the output stream equals the iclkena=1 case, with valid words only on enabled cycles.
  - oprbs_ival count = 4.
- Assert irst_n low during DATA word 2:
  - all outputs 0 asynchronously.
  - the next istart begins a fresh burst, oburst_idx=0.
- istart pulsed while busy, and len=0:
  - the extra istart is ignored.
  - len=0 produces exactly 1 payload word with osop and oeop both seen.
